// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: default
// configuration, tag layout and pointer-advance helper.
package adder_sched_pkg;

  localparam int unsigned N_DEF           = 32'd4;
  localparam int unsigned NUM_REQ_DEF     = 32'd3;
  localparam int unsigned ADD_LATENCY_DEF = 32'd2;

  // Width of a requester ID; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req < 32'd2) ? 32'd1 : $clog2(num_req);
  endfunction

  localparam int unsigned ID_W = id_width(NUM_REQ_DEF);

  // One tag-pipeline stage for the default configuration.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // Priority pointer after a grant to g: one past the winner, wrapping at
  // num_req-1 so non-power-of-two requester counts rotate correctly.
  function automatic int unsigned next_ptr(input int unsigned g,
                                           input int unsigned num_req);
    return (g == num_req - 32'd1) ? 32'd0 : g + 32'd1;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: searches the request vector
// starting at ptr_i and wrapping, returns a one-hot grant and winner ID.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 32'd3,
  parameter int unsigned ID_W    = 32'd2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_o
);

  int unsigned idx_s;
  logic        take_s;

  // First requester at or after the pointer (with wrap) wins.
  always_comb begin
    idx_s    = 32'd0;
    take_s   = 1'b0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_s    = (32'(ptr_i) + k) % NUM_REQ;
      take_s   = !any_o && req_i[idx_s];
      winner_o = take_s ? ID_W'(idx_s) : winner_o;
      any_o    = any_o | take_s;
    end
    gnt_o = any_o ? (NUM_REQ'(1) << winner_o) : '0;
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one external pipelined adder between
// NUM_REQ requesters; the requester ID rides a tag pipeline matched to the
// adder latency so each sum is returned to its originator.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int unsigned N           = N_DEF,
  parameter  int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter  int unsigned ADD_LATENCY = ADD_LATENCY_DEF,
  localparam int unsigned RID_W       = id_width(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_operand1,
  input  logic [NUM_REQ*N-1:0] req_operand2,
  output logic                 add_reset_n,
  output logic [N-1:0]         add_operand1,
  output logic [N-1:0]         add_operand2,
  input  logic [N-1:0]         add_result,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [RID_W-1:0]     rsp_id,
  output logic [N-1:0]         rsp_result,
  output logic                 busy
);

  // Tag stage sized for this instance's requester count.
  typedef struct packed {
    logic             vld;
    logic [RID_W-1:0] id;
  } stage_t;

  logic [RID_W-1:0]   ptr_q;
  logic [RID_W-1:0]   ptr_d;
  stage_t             tag_q [ADD_LATENCY];
  stage_t             last_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [RID_W-1:0]   winner_s;
  logic               any_s;
  logic               transfer_s;
  logic               inflight_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (RID_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt_s),
    .winner_o (winner_s),
    .any_o    (any_s)
  );

  // The adder resets in lockstep with the scheduler.
  assign add_reset_n = ~reset;

  // Grants are suppressed under reset; otherwise the adder never stalls.
  assign req_ready  = reset ? '0 : gnt_s;
  assign transfer_s = any_s & ~reset;

  // Winner's operands onto the adder, zero when nothing transfers.
  always_comb begin
    add_operand1 = '0;
    add_operand2 = '0;
    if (transfer_s) begin
      add_operand1 = req_operand1[32'(winner_s)*N +: N];
      add_operand2 = req_operand2[32'(winner_s)*N +: N];
    end else begin
      add_operand1 = '0;
      add_operand2 = '0;
    end
  end

  // Pointer moves one past the winner on a transfer, holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer_s) begin
      ptr_d = RID_W'(next_ptr(32'(winner_s), NUM_REQ));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register and tag pipeline; reset drops every in-flight tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      for (int unsigned j = 0; j < ADD_LATENCY; j++) begin
        tag_q[j] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      tag_q[0] <= '{vld: transfer_s, id: winner_s};
      for (int unsigned j = 1; j < ADD_LATENCY; j++) begin
        tag_q[j] <= tag_q[j-1];
      end
    end
  end

  // Any tag still travelling toward the response port.
  always_comb begin
    inflight_s = 1'b0;
    for (int unsigned j = 0; j < ADD_LATENCY; j++) begin
      inflight_s = inflight_s | tag_q[j].vld;
    end
  end

  assign last_s     = tag_q[ADD_LATENCY-1];
  assign rsp_valid  = last_s.vld ? (NUM_REQ'(1) << last_s.id) : '0;
  assign rsp_id     = last_s.id;
  assign rsp_result = add_result;
  assign busy       = ~reset & (inflight_s | (|req_valid));

endmodule
